// File: rtl/cic_comp_fir.sv
// cic_comp_fir -- decimating compensation FIR placed after the CIC decimator.
//
// Accepts CIC words on din/din_rdy, stores them in a TAPS-deep circular
// buffer and, on every DECIM-th accepted sample, runs one serial MAC pass
// over the window (one tap per enabled clock), then rounds, shifts and
// narrows the accumulator to DOUT_W bits.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   clk_en            global enable; every register holds when low
//   din, din_rdy      input sample and its one-cycle valid strobe
//   coef_we/addr/data coefficient write port (taken only in IDLE, not on MAC start)
//   status_clr        clears the sticky overrun / cfg_err flags
//   dout, dout_rdy    filtered sample (held) and its one-cycle strobe
//   busy              FSM outside IDLE
//   overrun           sticky: an input sample was dropped
//   cfg_err           sticky: a coefficient write was rejected
//
// Build option
//   CIC_COMP_SAT_EN   defined: saturate the result to DOUT_W; undefined: wrap.
//
// State table
//   S_IDLE  | accept samples (hold first, then din), accept coef writes
//   S_MAC   | TAPS cycles, one coef*sample product per cycle
//   S_ROUND | round/shift/narrow, register dout, pulse dout_rdy

module cic_comp_fir #(
    parameter int DIN_W     = 32,
    parameter int DOUT_W    = 24,
    parameter int COEF_W    = 18,
    parameter int TAPS      = 16,
    parameter int DECIM     = 2,
    parameter int ACC_W     = 54,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [DIN_W-1:0]         din,
    input  logic                     din_rdy,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     status_clr,
    output logic [DOUT_W-1:0]        dout,
    output logic                     dout_rdy,
    output logic                     busy,
    output logic                     overrun,
    output logic                     cfg_err
);

    localparam int AW  = $clog2(TAPS);
    localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW  = COEF_W + DIN_W;

    // Half-LSB rounding constant; zero when no shift is applied.
    localparam logic signed [ACC_W-1:0] RND =
        ACC_W'(OUT_SHIFT > 0) << ((OUT_SHIFT > 0) ? (OUT_SHIFT - 1) : 0);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

    state_t                   state;
    logic [DIN_W-1:0]         sbuf [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [AW-1:0]            wp;
    logic [AW-1:0]            newest;
    logic [AW-1:0]            k;
    logic [PHW-1:0]           phase;
    logic [DIN_W-1:0]         hold;
    logic                     hold_vld;
    logic signed [ACC_W-1:0]  acc;

    logic                     accept;
    logic [DIN_W-1:0]         acc_sample;
    logic                     start_mac;
    logic                     coef_ok;
    logic [AW-1:0]            rd_idx;
    logic signed [DIN_W-1:0]  x_rd;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic [DOUT_W-1:0]        dout_next;

    // The hold register has priority over din: it holds the older sample.
    assign accept     = (state == S_IDLE) && (hold_vld || din_rdy);
    assign acc_sample = hold_vld ? hold : din;
    assign start_mac  = accept && (phase == PHW'(DECIM - 1));
    assign coef_ok    = (state == S_IDLE) && !start_mac;

    // k counts down from TAPS-1; the sum is order-independent.
    assign rd_idx  = newest - k;
    assign x_rd    = sbuf[rd_idx];
    assign prod    = PW'(coef[k]) * PW'(x_rd);
    assign acc_rnd = acc + RND;

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};
    logic signed [ACC_W-1:0] r;
    assign r = acc_rnd >>> OUT_SHIFT;
    always_comb begin
        dout_next = r[DOUT_W-1:0];
        if (r > SAT_MAX)
            dout_next = SAT_MAX[DOUT_W-1:0];
        else if (r < SAT_MIN)
            dout_next = SAT_MIN[DOUT_W-1:0];
    end
`else
    assign dout_next = DOUT_W'(acc_rnd >>> OUT_SHIFT);
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wp       <= '0;
            newest   <= '0;
            k        <= '0;
            phase    <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            acc      <= '0;
            dout     <= '0;
            dout_rdy <= 1'b0;
            overrun  <= 1'b0;
            cfg_err  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                sbuf[i] <= '0;
                coef[i] <= (i == 0) ? COEF_W'(1) : '0;
            end
        end else if (clk_en) begin
            dout_rdy <= 1'b0;

            // Clear first so a same-cycle set event below wins.
            if (status_clr) begin
                overrun <= 1'b0;
                cfg_err <= 1'b0;
            end

            if (coef_we) begin
                if (coef_ok)
                    coef[coef_addr] <= coef_data;
                else
                    cfg_err <= 1'b1;
            end

            if (accept) begin
                sbuf[wp] <= acc_sample;
                newest   <= wp;
                wp       <= wp + 1'b1;
                if (start_mac)
                    phase <= '0;
                else
                    phase <= phase + 1'b1;
            end

            if (state == S_IDLE) begin
                // Draining the hold; a simultaneous din refills it.
                if (hold_vld) begin
                    hold_vld <= din_rdy;
                    if (din_rdy)
                        hold <= din;
                end
            end else if (din_rdy) begin
                if (!hold_vld) begin
                    hold     <= din;
                    hold_vld <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start_mac) begin
                        state <= S_MAC;
                        acc   <= '0;
                        k     <= AW'(TAPS - 1);
                    end
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (k == '0)
                        state <= S_ROUND;
                    else
                        k <= k - 1'b1;
                end
                S_ROUND: begin
                    dout     <= dout_next;
                    dout_rdy <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Testbench for cic_comp_fir: directed scenarios plus randomized coefficient
// and data traffic, checked against a windowed-sum reference model.
module tb_cic_comp_fir;

    localparam int TAPS      = 16;
    localparam int DECIM     = 2;
    localparam int OUT_SHIFT = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [31:0] din;
    logic        din_rdy;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [17:0] coef_data;
    logic        status_clr;
    logic [23:0] dout;
    logic        dout_rdy;
    logic        busy;
    logic        overrun;
    logic        cfg_err;

    cic_comp_fir dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .din        (din),
        .din_rdy    (din_rdy),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .status_clr (status_clr),
        .dout       (dout),
        .dout_rdy   (dout_rdy),
        .busy       (busy),
        .overrun    (overrun),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int hist[$];
    int coef_m[TAPS];

    // Output = sum over the last TAPS accepted samples, newest weighted by coef[0].
    function automatic logic [23:0] model();
        longint acc = 0;
        longint r;
        longint rnd;
        for (int t = 0; t < TAPS; t++) begin
            int idx;
            idx = hist.size() - 1 - t;
            if (idx >= 0)
                acc += longint'(coef_m[t]) * longint'(hist[idx]);
        end
        rnd = (OUT_SHIFT > 0) ? (longint'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : 0;
        r = (acc + rnd) >>> OUT_SHIFT;
`ifdef CIC_COMP_SAT_EN
        if (r > 64'sd8388607)
            r = 64'sd8388607;
        else if (r < -64'sd8388608)
            r = -64'sd8388608;
`endif
        return r[23:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (dout_rdy === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int t = 0; t < TAPS; t++) coef_m[t] = (t == 0) ? 1 : 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_rdy = 1'b0; coef_we = 1'b0; status_clr = 1'b0; clk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic write_coef(input int a, input int c);
        coef_addr = a[3:0];
        coef_data = c[17:0];
        coef_we = 1'b1;
        tick();
        coef_we = 1'b0;
        coef_m[a] = c;
    endtask

    task automatic feed(input int x, input string tag);
        int s;
        bit f;
        logic [23:0] e;
        s = cyc;
        din = x;
        din_rdy = 1'b1;
        tick();
        din_rdy = 1'b0;
        hist.push_back(x);
        if (hist.size() % DECIM == 0) begin
            e = model();
            wait_rdy(40, f);
            chk({tag, " rdy"}, 64'(f), 64'd1);
            chk({tag, " lat"}, 64'(cyc - s), 64'd18);
            chk({tag, " dout"}, 64'(dout), 64'(e));
        end
    endtask

    task automatic make_odd();
        if (hist.size() % DECIM != DECIM - 1) feed(11, "pad");
    endtask

    initial begin
        int s;
        int s0;
        bit f;
        logic [23:0] e;
        int vals[4];

        rst = 1'b1; clk_en = 1'b1; din = '0; din_rdy = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; status_clr = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset dout", 64'(dout), 64'd0);
        chk("reset dout_rdy", 64'(dout_rdy), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset overrun", 64'(overrun), 64'd0);
        chk("reset cfg_err", 64'(cfg_err), 64'd0);

        // Identity coefficients, samples spaced 20 clocks.
        vals = '{1000, 2000, 3000, 4000};
        for (int i = 0; i < 4; i++) begin
            s0 = cyc;
            feed(vals[i], "t1");
            if (i == 1) chk("t1 first", 64'(dout), 64'd2000);
            if (i == 3) chk("t1 second", 64'(dout), 64'd4000);
            while (cyc - s0 < 20) tick();
        end

        // Full-scale inputs through the identity filter.
        feed(32'h7FFFFFFF, "t3 max");
        feed(32'h7FFFFFFF, "t3 max");
`ifdef CIC_COMP_SAT_EN
        chk("t3 max lit", 64'(dout), 64'h7FFFFF);
`else
        chk("t3 max lit", 64'(dout), 64'hFFFFFF);
`endif
        feed(32'h80000000, "t3 min");
        feed(32'h80000000, "t3 min");
`ifdef CIC_COMP_SAT_EN
        chk("t3 min lit", 64'(dout), 64'h800000);
`else
        chk("t3 min lit", 64'(dout), 64'h000000);
`endif

        // Boxcar of ones on a constant input.
        do_reset();
        for (int t = 0; t < TAPS; t++) write_coef(t, 1);
        for (int i = 0; i < 32; i++) begin
            feed(100, "t2");
            if (i == 1) chk("t2 first", 64'(dout), 64'd200);
        end
        chk("t2 settled", 64'(dout), 64'd1600);

        // Three samples during MAC: one held, two dropped.
        make_odd();
        s = cyc;
        din = 1000; din_rdy = 1'b1;
        tick();
        hist.push_back(1000);
        e = model();
        din = 20000;   tick();
        din = 300000;  tick();
        din = 4000000; tick();
        din_rdy = 1'b0;
        hist.push_back(20000);
        wait_rdy(40, f);
        chk("t4 rdy", 64'(f), 64'd1);
        chk("t4 lat", 64'(cyc - s), 64'd18);
        chk("t4 dout", 64'(dout), 64'(e));
        chk("t4 overrun set", 64'(overrun), 64'd1);
        tick(); tick();
        chk("t4 hold no mac", 64'(busy), 64'd0);
        chk("t4 overrun sticky", 64'(overrun), 64'd1);
        feed(50, "t4 after");
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("t4 overrun clr", 64'(overrun), 64'd0);

        // clk_en low for 10 cycles mid-MAC.
        make_odd();
        s = cyc;
        din = 777; din_rdy = 1'b1;
        tick();
        din_rdy = 1'b0;
        hist.push_back(777);
        e = model();
        repeat (5) tick();
        chk("t5 busy", 64'(busy), 64'd1);
        clk_en = 1'b0;
        repeat (10) tick();
        clk_en = 1'b1;
        wait_rdy(60, f);
        chk("t5 rdy", 64'(f), 64'd1);
        chk("t5 lat", 64'(cyc - s), 64'd28);
        chk("t5 dout", 64'(dout), 64'(e));

        // Random coefficients and data.
        for (int t = 0; t < TAPS; t++)
            write_coef(t, int'($urandom_range(0, 262143)) - 131072);
        for (int i = 0; i < 24; i++) feed(int'($urandom), "rnd");

        // Reset in the middle of a MAC pass.
        make_odd();
        din = 12345; din_rdy = 1'b1;
        tick();
        din_rdy = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 rst dout", 64'(dout), 64'd0);
        chk("t5 rst busy", 64'(busy), 64'd0);
        tick();
        chk("t5 rst busy next", 64'(busy), 64'd0);
        wait_rdy(30, f);
        chk("t5 rst no rdy", 64'(f), 64'd0);
        model_reset();

        // Coefficient writes outside legal windows.
        feed(123, "t6 a");
        din = 456; din_rdy = 1'b1;
        coef_addr = 4'd0; coef_data = 18'd7; coef_we = 1'b1;
        tick();
        din_rdy = 1'b0; coef_we = 1'b0;
        hist.push_back(456);
        e = model();
        chk("t6 start write err", 64'(cfg_err), 64'd1);
        status_clr = 1'b1; coef_we = 1'b1;
        tick();
        status_clr = 1'b0; coef_we = 1'b0;
        chk("t6 set wins", 64'(cfg_err), 64'd1);
        wait_rdy(40, f);
        chk("t6 rdy", 64'(f), 64'd1);
        chk("t6 coef unchanged", 64'(dout), 64'(e));
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("t6 clr", 64'(cfg_err), 64'd0);
        write_coef(0, 7);
        chk("t6 idle write ok", 64'(cfg_err), 64'd0);
        feed(10, "t6 b");
        feed(20, "t6 c");
        chk("t6 coef applied", 64'(dout), 64'd140);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
